alu_seq_param: RTL and testbench

//   Parametrised multi-cycle ALU: unsigned add, sub, shift-add multiply and restoring 2W/W divide.

---
 rtl/alu_seq_param.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_seq_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// Multi-cycle unsigned ALU: add, sub, shift-add multiply and restoring 2W/W divide.
// Operands arrive serially after a _begin strobe; results leave as one or two registered words.
module alu_seq_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             _begin,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             valid,
  output logic             _end,
  output logic             busy
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_A = 3'd1,
    S_LD_B = 3'd2,
    S_LD_C = 3'd3,
    S_CALC = 3'd4,
    S_OUT1 = 3'd5,
    S_OUT2 = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  word2_q, word2_d;
  logic [W-1:0]  out_q, out_d;
  logic [3:0]    flags_q, flags_d;
  logic          valid_q, valid_d;
  logic          end_q, end_d;
  logic          busy_q, busy_d;

  // Single-cycle add/sub results with carry/borrow in the top bit
  logic [W:0]   add_res, sub_res;
  logic         add_ovf, sub_ovf;
  // One shift-add multiply step: {hi,lo} accumulates product, lo holds remaining multiplier bits
  logic [W:0]   mul_sum;
  logic [W-1:0] mul_hi, mul_lo;
  // One restoring-divide step: hi holds the partial remainder, lo shifts dividend out / quotient in
  logic [W:0]   div_sh, div_diff;
  logic         div_ge, div_err;
  logic [W-1:0] div_rem, div_quo;
  logic         last_step;

  assign add_res  = {1'b0, a_q} + {1'b0, lo_q};
  assign sub_res  = {1'b0, a_q} - {1'b0, lo_q};
  assign add_ovf  = (a_q[W-1] == lo_q[W-1]) && (add_res[W-1] != a_q[W-1]);
  assign sub_ovf  = (a_q[W-1] != lo_q[W-1]) && (sub_res[W-1] != a_q[W-1]);

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign mul_hi   = mul_sum[W:1];
  assign mul_lo   = {mul_sum[0], lo_q[W-1:1]};

  assign div_sh   = {hi_q, lo_q[W-1]};
  assign div_diff = div_sh - {1'b0, d_q};
  assign div_ge   = (div_sh >= {1'b0, d_q});
  assign div_rem  = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
  assign div_quo  = {lo_q[W-2:0], div_ge};
  // Quotient cannot fit in W bits when the high dividend word reaches the divisor (covers D==0)
  assign div_err  = (hi_q >= d_q);

  assign last_step = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    word2_d = word2_q;
    out_d   = '0;
    flags_d = '0;
    valid_d = 1'b0;
    end_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (_begin) begin
          op_d    = op;
          state_d = S_LD_A;
        end
      end
      S_LD_A: begin
        a_d     = in;
        hi_d    = in;
        state_d = S_LD_B;
      end
      S_LD_B: begin
        lo_d  = in;
        cnt_d = '0;
        if (op_q == OP_DIV) begin
          state_d = S_LD_C;
        end else begin
          if (op_q == OP_MUL) hi_d = '0;
          state_d = S_CALC;
        end
      end
      S_LD_C: begin
        d_d     = in;
        state_d = S_CALC;
      end
      S_CALC: begin
        case (op_q)
          OP_ADD: begin
            out_d   = add_res[W-1:0];
            flags_d = {1'b0, add_ovf, add_res[W], (add_res[W-1:0] == '0)};
            valid_d = 1'b1;
            end_d   = 1'b1;
            state_d = S_OUT1;
          end
          OP_SUB: begin
            out_d   = sub_res[W-1:0];
            flags_d = {1'b0, sub_ovf, sub_res[W], (sub_res[W-1:0] == '0)};
            valid_d = 1'b1;
            end_d   = 1'b1;
            state_d = S_OUT1;
          end
          OP_MUL: begin
            hi_d  = mul_hi;
            lo_d  = mul_lo;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
              out_d   = mul_hi;
              word2_d = mul_lo;
              flags_d = {3'b000, ({mul_hi, mul_lo} == '0)};
              valid_d = 1'b1;
              state_d = S_OUT1;
            end
          end
          default: begin
            if ((cnt_q == '0) && div_err) begin
              out_d   = '1;
              word2_d = '0;
              flags_d = 4'b1000;
              valid_d = 1'b1;
              state_d = S_OUT1;
            end else begin
              hi_d  = div_rem;
              lo_d  = div_quo;
              cnt_d = cnt_q + CW'(1);
              if (last_step) begin
                out_d   = div_quo;
                word2_d = div_rem;
                flags_d = {3'b000, (div_quo == '0)};
                valid_d = 1'b1;
                state_d = S_OUT1;
              end
            end
          end
        endcase
      end
      S_OUT1: begin
        if (op_q[1]) begin
          out_d   = word2_q;
          flags_d = flags_q;
          valid_d = 1'b1;
          end_d   = 1'b1;
          state_d = S_OUT2;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OUT2: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      word2_q <= '0;
      out_q   <= '0;
      flags_q <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      word2_q <= word2_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  assign out   = out_q;
  assign flags = flags_q;
  assign valid = valid_q;
  assign _end  = end_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param: vector table for WIDTH=8 plus hand sequences
// for busy-time _begin, mid-operation reset and a WIDTH=16 multiply.
module tb_alu_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        bgn8;
  logic [1:0]  op8;
  logic [7:0]  in8;
  logic [7:0]  out8;
  logic [3:0]  flags8;
  logic        valid8, end8, busy8;

  logic        bgn16;
  logic [1:0]  op16;
  logic [15:0] in16;
  logic [15:0] out16;
  logic [3:0]  flags16;
  logic        valid16, end16, busy16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), ._begin(bgn8), .op(op8), .in(in8),
    .out(out8), .flags(flags8), .valid(valid8), ._end(end8), .busy(busy8)
  );

  alu_seq_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), ._begin(bgn16), .op(op16), .in(in16),
    .out(out16), .flags(flags16), .valid(valid16), ._end(end16), .busy(busy16)
  );

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] w1;
    logic [3:0] f1;
    logic [7:0] w2;
    bit         two;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives E0..E2 (E3 for div); operand bus and op carry junk outside their capture edges
  task automatic start8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, output int e);
    bgn8 = 1'b1; op8 = o; in8 = 8'h5A;
    step();
    bgn8 = 1'b0; op8 = ~o; in8 = a;
    step();
    in8 = b;
    step();
    e = 2;
    if (o == 2'b11) begin
      in8 = d;
      step();
      e = 3;
    end
    in8 = 8'hA5;
  endtask

  task automatic wait_valid8(inout int e);
    while (!valid8 && e < 60) begin
      step();
      e++;
    end
  endtask

  task automatic check_idle8(input string name);
    check({name, "/idle_out"},   32'(out8),   32'h0);
    check({name, "/idle_flags"}, 32'(flags8), 32'h0);
    check({name, "/idle_valid"}, 32'(valid8), 32'h0);
    check({name, "/idle_end"},   32'(end8),   32'h0);
    check({name, "/idle_busy"},  32'(busy8),  32'h0);
  endtask

  initial begin
    int e;

    //             name        op     a      b      d      w1     f1       w2     two lat
    vecs[0]  = '{"add_2_3",    2'b00, 8'h02, 8'h03, 8'h00, 8'h05, 4'b0000, 8'h00, 0,  3};
    vecs[1]  = '{"sub_2_7",    2'b01, 8'h02, 8'h07, 8'h00, 8'hFB, 4'b0010, 8'h00, 0,  3};
    vecs[2]  = '{"sub_ovf",    2'b01, 8'h80, 8'h01, 8'h00, 8'h7F, 4'b0100, 8'h00, 0,  3};
    vecs[3]  = '{"add_wrap",   2'b00, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 8'h00, 0,  3};
    vecs[4]  = '{"add_ovf",    2'b00, 8'h7F, 8'h01, 8'h00, 8'h80, 4'b0100, 8'h00, 0,  3};
    vecs[5]  = '{"mul_c5_4",   2'b10, 8'hC5, 8'h04, 8'h00, 8'h03, 4'b0000, 8'h14, 1, 10};
    vecs[6]  = '{"mul_zero",   2'b10, 8'h00, 8'h55, 8'h00, 8'h00, 4'b0001, 8'h00, 1, 10};
    vecs[7]  = '{"mul_ff_ff",  2'b10, 8'hFF, 8'hFF, 8'h00, 8'hFE, 4'b0000, 8'h01, 1, 10};
    vecs[8]  = '{"div_3112",   2'b11, 8'h31, 8'h12, 8'h7B, 8'h66, 4'b0000, 8'h10, 1, 11};
    vecs[9]  = '{"div_qzero",  2'b11, 8'h00, 8'h03, 8'h10, 8'h00, 4'b0001, 8'h03, 1, 11};
    vecs[10] = '{"div_max",    2'b11, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 4'b0000, 8'hFE, 1, 11};
    vecs[11] = '{"div_by0",    2'b11, 8'h01, 8'h23, 8'h00, 8'hFF, 4'b1000, 8'h00, 1,  4};
    vecs[12] = '{"div_qovf",   2'b11, 8'h20, 8'h00, 8'h10, 8'hFF, 4'b1000, 8'h00, 1,  4};

    rst = 1'b0;
    bgn8 = 1'b0; op8 = 2'b00; in8 = 8'h00;
    bgn16 = 1'b0; op16 = 2'b00; in16 = 16'h0000;
    step();
    step();
    check_idle8("reset");
    rst = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      start8(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, e);
      wait_valid8(e);
      check({vecs[i].name, "/lat"},   32'(e),      32'(vecs[i].lat));
      check({vecs[i].name, "/w1"},    32'(out8),   32'(vecs[i].w1));
      check({vecs[i].name, "/f1"},    32'(flags8), 32'(vecs[i].f1));
      check({vecs[i].name, "/end1"},  32'(end8),   32'(!vecs[i].two));
      check({vecs[i].name, "/busy1"}, 32'(busy8),  32'h1);
      step();
      if (vecs[i].two) begin
        check({vecs[i].name, "/w2"},     32'(out8),   32'(vecs[i].w2));
        check({vecs[i].name, "/valid2"}, 32'(valid8), 32'h1);
        check({vecs[i].name, "/end2"},   32'(end8),   32'h1);
        step();
      end
      check_idle8(vecs[i].name);
    end

    // _begin pulsed while busy (sampled at E4) must not disturb or queue anything
    start8(2'b10, 8'hC5, 8'h04, 8'h00, e);
    step();
    e = 3;
    bgn8 = 1'b1; op8 = 2'b00;
    step();
    e = 4;
    bgn8 = 1'b0;
    wait_valid8(e);
    check("busybegin/lat", 32'(e),    32'd10);
    check("busybegin/w1",  32'(out8), 32'h03);
    step();
    check("busybegin/w2",  32'(out8), 32'h14);
    check("busybegin/end", 32'(end8), 32'h1);
    step();
    step();
    check_idle8("busybegin");

    // Asynchronous reset mid-multiply, then a clean add
    start8(2'b10, 8'hC5, 8'h04, 8'h00, e);
    step();
    step();
    step();
    check("midrst/busy_before", 32'(busy8), 32'h1);
    rst = 1'b0;
    #1;
    check_idle8("midrst");
    step();
    rst = 1'b1;
    step();
    check_idle8("midrst_hold");
    start8(2'b00, 8'h02, 8'h03, 8'h00, e);
    wait_valid8(e);
    check("postrst/lat", 32'(e),      32'd3);
    check("postrst/w1",  32'(out8),   32'h05);
    check("postrst/f1",  32'(flags8), 32'h0);
    step();
    check_idle8("postrst");

    // WIDTH=16 multiply of the largest operands
    bgn16 = 1'b1; op16 = 2'b10; in16 = 16'h1234;
    step();
    bgn16 = 1'b0; op16 = 2'b00; in16 = 16'hFFFF;
    step();
    step();
    in16 = 16'h0000;
    e = 2;
    while (!valid16 && e < 80) begin
      step();
      e++;
    end
    check("w16mul/lat",  32'(e),     32'd18);
    check("w16mul/w1",   32'(out16), 32'hFFFE);
    check("w16mul/end1", 32'(end16), 32'h0);
    step();
    check("w16mul/w2",   32'(out16), 32'h0001);
    check("w16mul/end2", 32'(end16), 32'h1);
    step();
    check("w16mul/busy", 32'(busy16),  32'h0);
    check("w16mul/valid", 32'(valid16), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
